// File: rtl/cv32e40s_alert_handler.sv
// cv32e40s_alert_handler
//   SoC-side receiver for the core alert levels. Minor alerts are rate-checked
//   over a window that opens on the first minor. A major alert, or reaching
//   MINOR_THRESHOLD minors inside one window, escalates. Escalation that is not
//   cleared within ESC_DELAY cycles becomes a sticky fatal.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   alert_minor_i   - minor alert, one event per high cycle
//   alert_major_i   - major alert, one event per high cycle
//   clear_i         - software clear of escalation
//   minor_irq_o     - one-cycle pulse per minor event
//   escalate_o      - escalation request (ESCALATE or FATAL)
//   fatal_o         - sticky fatal, cleared only by rst
//   state_o         - 00 IDLE, 01 ARMED, 10 ESCALATE, 11 FATAL
//   minor_total_o   - saturating lifetime minor count
//   major_total_o   - saturating lifetime major count
module cv32e40s_alert_handler #(
  parameter int unsigned MINOR_THRESHOLD = 4,
  parameter int unsigned WINDOW_CYCLES   = 1024,
  parameter int unsigned ESC_DELAY       = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alert_minor_i,
  input  logic             alert_major_i,
  input  logic             clear_i,
  output logic             minor_irq_o,
  output logic             escalate_o,
  output logic             fatal_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] minor_total_o,
  output logic [CNT_W-1:0] major_total_o
);

  localparam int unsigned TMR_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned DLY_W = (ESC_DELAY > 1) ? $clog2(ESC_DELAY) : 1;

  localparam logic [TMR_W-1:0] TMR_INIT  = TMR_W'(WINDOW_CYCLES - 2);
  localparam logic [DLY_W-1:0] DLY_INIT  = DLY_W'(ESC_DELAY - 1);
  localparam logic [8:0]       THRESHOLD = 9'(MINOR_THRESHOLD);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ARMED    = 2'b01,
    ESCALATE = 2'b10,
    FATAL    = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       win_cnt_q, win_cnt_d;
  logic [8:0]       win_cnt_inc;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [DLY_W-1:0] dly_q, dly_d;

  assign win_cnt_inc = {1'b0, win_cnt_q} + 9'd1;

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    timer_d   = timer_q;
    dly_d     = dly_q;

    case (state_q)
      IDLE: begin
        win_cnt_d = '0;
        timer_d   = '0;
        if (alert_major_i) begin
          state_d = ESCALATE;
          dly_d   = DLY_INIT;
        end else if (alert_minor_i) begin
          if (MINOR_THRESHOLD == 1) begin
            state_d = ESCALATE;
            dly_d   = DLY_INIT;
          end else begin
            // Window opened this cycle: remaining ARMED cycles are
            // WINDOW_CYCLES-1, counted down to zero inclusive.
            state_d   = ARMED;
            win_cnt_d = 8'd1;
            timer_d   = TMR_INIT;
          end
        end
      end

      ARMED: begin
        timer_d = timer_q - 1'b1;
        if (alert_minor_i) win_cnt_d = win_cnt_inc[7:0];

        if (alert_major_i || (alert_minor_i && (win_cnt_inc >= THRESHOLD))) begin
          state_d   = ESCALATE;
          dly_d     = DLY_INIT;
          win_cnt_d = '0;
          timer_d   = '0;
        end else if (timer_q == '0) begin
          // A sub-threshold minor in the expiry cycle dies with this window.
          state_d   = IDLE;
          win_cnt_d = '0;
          timer_d   = '0;
        end
      end

      ESCALATE: begin
        if (clear_i && !alert_major_i) begin
          state_d   = IDLE;
          win_cnt_d = '0;
          timer_d   = '0;
        end else if (clear_i) begin
          // Clear collided with a fresh major: restart the escalation delay.
          dly_d = DLY_INIT;
        end else if (dly_q == '0) begin
          state_d = FATAL;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end

      FATAL: state_d = FATAL;

      default: state_d = FATAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      win_cnt_q     <= '0;
      timer_q       <= '0;
      dly_q         <= '0;
      minor_irq_o   <= 1'b0;
      escalate_o    <= 1'b0;
      fatal_o       <= 1'b0;
      minor_total_o <= '0;
      major_total_o <= '0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      timer_q     <= timer_d;
      dly_q       <= dly_d;
      minor_irq_o <= alert_minor_i;
      escalate_o  <= state_d[1];
      fatal_o     <= (state_d == FATAL);
      if (alert_minor_i && (minor_total_o != '1)) minor_total_o <= minor_total_o + 1'b1;
      if (alert_major_i && (major_total_o != '1)) major_total_o <= major_total_o + 1'b1;
    end
  end

  assign state_o = state_q;

endmodule
